// File: rtl/fcs_check.sv
// Frame-check-sequence validator for the RMII receive dibit stream.
// Runs a CRC-32 over each frame (payload plus transmitted FCS) and issues a
// one-cycle pass/kill verdict once valid drops, plus wrap-around statistics.

// CRC-32 engine, two bits per clock, axiid[0] shifted in first.
// axiod is the complemented register, so a clean frame leaves the magic residue.
module crc32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        axiiv,
  input  logic [1:0]  axiid,
  output logic [31:0] axiod
);

  localparam logic [31:0] Poly = 32'h04C1_1DB7;

  logic [31:0] lfsr_q;
  logic [31:0] lfsr_d;

  function automatic logic [31:0] crc_bit(input logic [31:0] c, input logic b);
    return {c[30:0], 1'b0} ^ ((c[31] ^ b) ? Poly : 32'h0);
  endfunction

  // Advance the LFSR by one dibit, earlier wire bit first
  always_comb begin
    lfsr_d = crc_bit(crc_bit(lfsr_q, axiid[0]), axiid[1]);
  end

  // Register holds while axiiv is low so the residue can be read after the frame
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= '1;
    end else if (axiiv) begin
      lfsr_q <= lfsr_d;
    end
  end

  assign axiod = ~lfsr_q;

endmodule

module fcs_check #(
  parameter logic [31:0] MAGIC      = 32'h38FB_2284,
  parameter int unsigned MIN_DIBITS = 256,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             axiiv,
  input  logic [1:0]       axiid,
  output logic             done,
  output logic             kill,
  output logic [CNT_W-1:0] good_count,
  output logic [CNT_W-1:0] bad_count
);

  localparam logic [10:0] MinLen = 11'(MIN_DIBITS);

  typedef enum logic [1:0] {StIdle, StRecv, StGap, StDrop} state_e;

  state_e           state_q, state_d;
  logic [10:0]      cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             kill_q, kill_d;
  logic [CNT_W-1:0] good_q, good_d;
  logic [CNT_W-1:0] bad_q, bad_d;
  logic             crc_clr;
  logic             crc_rst;
  logic [31:0]      crc_res;
  logic             frame_bad;

  assign crc_rst = rst | crc_clr;

  crc32 u_crc32 (
    .clk   (clk),
    .rst   (crc_rst),
    .axiiv (axiiv),
    .axiid (axiid),
    .axiod (crc_res)
  );

  // Residue, runt and partial-byte checks, evaluated in the cycle valid drops
  assign frame_bad = (crc_res != MAGIC) || (cnt_q < MinLen) || (cnt_q[1:0] != 2'b00);

  // Next-state, verdict and statistics update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    kill_d  = 1'b0;
    good_d  = good_q;
    bad_d   = bad_q;
    crc_clr = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (axiiv) begin
          state_d = StRecv;
          cnt_d   = 11'd1;
        end else begin
          crc_clr = 1'b1;
        end
      end
      StRecv: begin
        if (axiiv) begin
          if (cnt_q != '1) begin
            cnt_d = cnt_q + 11'd1;
          end
        end else begin
          done_d  = 1'b1;
          kill_d  = frame_bad;
          state_d = StGap;
          if (frame_bad) begin
            bad_d = bad_q + CNT_W'(1);
          end else begin
            good_d = good_q + CNT_W'(1);
          end
        end
      end
      StGap: begin
        // Single-cycle gap; a frame starting here broke the inter-frame gap
        crc_clr = 1'b1;
        state_d = axiiv ? StDrop : StIdle;
      end
      StDrop: begin
        if (!axiiv) begin
          done_d  = 1'b1;
          kill_d  = 1'b1;
          bad_d   = bad_q + CNT_W'(1);
          state_d = StGap;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset overrides any pending verdict
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      kill_q  <= 1'b0;
      good_q  <= '0;
      bad_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      kill_q  <= kill_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
    end
  end

  assign done       = done_q;
  assign kill       = kill_q;
  assign good_count = good_q;
  assign bad_count  = bad_q;

endmodule

// File: tb/tb_fcs_check.sv
// Directed bench for fcs_check. Instance a uses a 16-dibit minimum length;
// instance b keeps the default minimum with 2-bit counters to expose wrapping.
module tb_fcs_check;

  logic        clk = 1'b0;
  logic        rst;
  logic        axiiv;
  logic [1:0]  axiid;

  logic        done_a, kill_a;
  logic [15:0] good_a, bad_a;
  logic        done_b, kill_b;
  logic [1:0]  good_b, bad_b;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned pulses_a = 0;

  logic [1:0]  frame_q [$];
  logic [63:0] msg = 64'h6769_60D1_9D78_5A5B;
  logic [1:0]  wrap_tab [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

  always #10 clk = ~clk;

  fcs_check #(.MIN_DIBITS(16)) u_dut_a (
    .clk        (clk),
    .rst        (rst),
    .axiiv      (axiiv),
    .axiid      (axiid),
    .done       (done_a),
    .kill       (kill_a),
    .good_count (good_a),
    .bad_count  (bad_a)
  );

  fcs_check #(.CNT_W(2)) u_dut_b (
    .clk        (clk),
    .rst        (rst),
    .axiiv      (axiiv),
    .axiid      (axiid),
    .done       (done_b),
    .kill       (kill_b),
    .good_count (good_b),
    .bad_count  (bad_b)
  );

  // Count verdict pulses on instance a, sampled mid-cycle
  always @(negedge clk) begin
    if (done_a === 1'b1) pulses_a++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    axiiv = 1'b0;
    axiid = 2'b00;
    step();
    rst = 1'b0;
  endtask

  // Byte-wise reflected Ethernet CRC of the message, complemented for transmission
  function automatic logic [31:0] ref_fcs();
    logic [31:0] c = 32'hFFFF_FFFF;
    for (int i = 0; i < 8; i++) begin
      c = c ^ {24'h0, msg[63-8*i -: 8]};
      for (int k = 0; k < 8; k++) begin
        c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
    end
    return ~c;
  endfunction

  // Message bytes first-to-last, each byte least-significant dibit first,
  // then the FCS least-significant dibit first, then optional stray dibits
  task automatic build_frame(input logic [31:0] fcs_flip, input int extra);
    logic [7:0]  b;
    logic [31:0] fcs;
    frame_q.delete();
    for (int i = 0; i < 8; i++) begin
      b = msg[63-8*i -: 8];
      for (int k = 0; k < 4; k++) frame_q.push_back(b[2*k +: 2]);
    end
    fcs = ref_fcs() ^ fcs_flip;
    for (int k = 0; k < 16; k++) frame_q.push_back(fcs[2*k +: 2]);
    for (int k = 0; k < extra; k++) frame_q.push_back(2'(k + 1));
  endtask

  // Drive the frame, then drop valid; returns at the start of the end cycle
  task automatic send_frame(input string tag);
    foreach (frame_q[i]) begin
      axiiv = 1'b1;
      axiid = frame_q[i];
      step();
    end
    axiiv = 1'b0;
    axiid = 2'b11;
    check({tag, ".early_done"}, 32'(done_a), 32'd0);
  endtask

  task automatic verdict_a(input string tag, input logic k, input int g, input int bd);
    check({tag, ".done"}, 32'(done_a), 32'd1);
    check({tag, ".kill"}, 32'(kill_a), 32'(k));
    check({tag, ".good"}, 32'(good_a), 32'(g));
    check({tag, ".bad"},  32'(bad_a),  32'(bd));
  endtask

  initial begin
    int unsigned snap;
    rst   = 1'b1;
    axiiv = 1'b0;
    axiid = 2'b00;
    step();
    do_reset();
    check("reset.done", 32'(done_a), 32'd0);
    check("reset.kill", 32'(kill_a), 32'd0);
    check("reset.good", 32'(good_a), 32'd0);
    check("reset.bad",  32'(bad_a),  32'd0);

    // Good 48-dibit frame; the default-length instance sees it as a runt
    build_frame(32'h0, 0);
    send_frame("good");
    step();
    verdict_a("good", 1'b0, 1, 0);
    check("runt.done", 32'(done_b), 32'd1);
    check("runt.kill", 32'(kill_b), 32'd1);
    check("runt.bad",  32'(bad_b),  32'd1);
    check("runt.good", 32'(good_b), 32'd0);
    step();
    check("good.one_cycle", 32'(done_a), 32'd0);

    // Corrupted FCS
    do_reset();
    build_frame(32'h0000_0001, 0);
    send_frame("corrupt");
    step();
    verdict_a("corrupt", 1'b1, 0, 1);

    // Partial byte: 50 dibits
    do_reset();
    build_frame(32'h0, 2);
    send_frame("partial");
    step();
    verdict_a("partial", 1'b1, 0, 1);

    // Back-to-back with a 1-cycle gap: second frame is dropped
    do_reset();
    build_frame(32'h0, 0);
    send_frame("b2b1.f1");
    step();
    verdict_a("b2b1.f1", 1'b0, 1, 0);
    send_frame("b2b1.f2");
    step();
    verdict_a("b2b1.f2", 1'b1, 1, 1);

    // Back-to-back with a 2-cycle gap: both good
    do_reset();
    send_frame("b2b2.f1");
    step();
    verdict_a("b2b2.f1", 1'b0, 1, 0);
    step();
    send_frame("b2b2.f2");
    step();
    verdict_a("b2b2.f2", 1'b0, 2, 0);

    // Reset after 20 dibits: no verdict for the aborted frame
    do_reset();
    step();
    for (int i = 0; i < 20; i++) begin
      axiiv = 1'b1;
      axiid = frame_q[i];
      step();
    end
    snap = pulses_a;
    do_reset();
    step();
    step();
    check("abort.no_done", pulses_a - snap, 32'd0);
    check("abort.known", 32'($isunknown({done_a, kill_a, good_a, bad_a})), 32'd0);
    check("abort.good", 32'(good_a), 32'd0);
    send_frame("abort.next");
    step();
    verdict_a("abort.next", 1'b0, 1, 0);

    // Reset asserted in the end cycle suppresses the verdict
    do_reset();
    send_frame("rst_end");
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_end.done", 32'(done_a), 32'd0);
    check("rst_end.good", 32'(good_a), 32'd0);

    // Five frames: 2-bit bad counter on instance b wraps through zero
    do_reset();
    for (int f = 0; f < 5; f++) begin
      send_frame("wrap");
      step();
      check("wrap.good_a", 32'(good_a), 32'(f + 1));
      check("wrap.bad_b", 32'(bad_b), 32'(wrap_tab[f]));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
